// File: rtl/ram_arb_pkg.sv
// Shared definitions for the scratch-RAM port arbiter: state encoding,
// default geometry and requester port indices.
package ram_arb_pkg;

  localparam int unsigned A_DEFAULT   = 4;
  localparam int unsigned D_DEFAULT   = 4;

  localparam int unsigned PORT_SOLVER = 0;
  localparam int unsigned PORT_HOST   = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-request round-robin arbiter: one-hot grant, ties go to the port that
// was not granted most recently.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // last_q names the port granted most recently; reset value lets the solver win the first tie
  logic last_q;
  logic last_d;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req[PORT_SOLVER] && req[PORT_HOST]) begin
        gnt = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end

    last_d = last_q;
    if (gnt[PORT_SOLVER]) begin
      last_d = 1'b0;
    end else if (gnt[PORT_HOST]) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a single-port async-read RAM between the solver (port 0) and host
// (port 1). Define RAM_CLEAR_EN to zero the RAM after reset before serving requests.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned A = A_DEFAULT,
  parameter int unsigned D = D_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req0_we,
  input  logic [A-1:0] req0_addr,
  input  logic [D-1:0] req0_wdata,
  output logic         req0_ready,
  output logic         req0_rvalid,
  output logic [D-1:0] req0_rdata,
  input  logic         req1_valid,
  input  logic         req1_we,
  input  logic [A-1:0] req1_addr,
  input  logic [D-1:0] req1_wdata,
  output logic         req1_ready,
  output logic         req1_rvalid,
  output logic [D-1:0] req1_rdata,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_din,
  output logic         ram_we,
  input  logic [D-1:0] ram_dout,
  output logic         busy
);

  logic         clearing;
  logic [A-1:0] clr_addr;
  logic         arb_en;
  logic [1:0]   gnt;

`ifdef RAM_CLEAR_EN
  arb_state_e   state_q, state_d;
  logic [A-1:0] clr_addr_q, clr_addr_d;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == '1) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign clearing = (state_q == ST_CLEAR);
  assign clr_addr = clr_addr_q;
`else
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif

  // Grants are combinational from valid, so gate on rst_n to keep ready low while reset is held
  assign arb_en = rst_n & ~clearing;
  assign busy   = clearing;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   ({req1_valid, req0_valid}),
    .gnt   (gnt)
  );

  assign req0_ready = gnt[PORT_SOLVER];
  assign req1_ready = gnt[PORT_HOST];

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (clearing) begin
      ram_addr = clr_addr;
      ram_we   = 1'b1;
    end else if (gnt[PORT_SOLVER]) begin
      ram_addr = req0_addr;
      ram_din  = req0_wdata;
      ram_we   = req0_we;
    end else if (gnt[PORT_HOST]) begin
      ram_addr = req1_addr;
      ram_din  = req1_wdata;
      ram_we   = req1_we;
    end
  end

  logic         rvalid0_q, rvalid0_d;
  logic         rvalid1_q, rvalid1_d;
  logic [D-1:0] rdata0_q, rdata0_d;
  logic [D-1:0] rdata1_q, rdata1_d;

  always_comb begin
    rvalid0_d = gnt[PORT_SOLVER] & ~req0_we;
    rvalid1_d = gnt[PORT_HOST] & ~req1_we;
    rdata0_d  = rvalid0_d ? ram_dout : rdata0_q;
    rdata1_d  = rvalid1_d ? ram_dout : rdata1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign req0_rvalid = rvalid0_q;
  assign req1_rvalid = rvalid1_q;
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter against a transaction-level model
// of round-robin arbitration and RAM contents; follows RAM_CLEAR_EN if defined.
module tb_ram_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_we, req1_valid, req1_we;
  logic [3:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic       req0_ready, req0_rvalid, req1_ready, req1_rvalid;
  logic [3:0] req0_rdata, req1_rdata;
  logic [3:0] ram_addr, ram_din, ram_dout;
  logic       ram_we;
  logic       busy;

  int checks = 0;
  int errors = 0;

  ram_port_arbiter #(.A(4), .D(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_we     (req0_we),
    .req0_addr   (req0_addr),
    .req0_wdata  (req0_wdata),
    .req0_ready  (req0_ready),
    .req0_rvalid (req0_rvalid),
    .req0_rdata  (req0_rdata),
    .req1_valid  (req1_valid),
    .req1_we     (req1_we),
    .req1_addr   (req1_addr),
    .req1_wdata  (req1_wdata),
    .req1_ready  (req1_ready),
    .req1_rvalid (req1_rvalid),
    .req1_rdata  (req1_rdata),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_we      (ram_we),
    .ram_dout    (ram_dout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: async read, write on the clock edge; fill_en preloads it
  logic [3:0] mem [16];
  logic [3:0] fill_data [16];
  bit         fill_en = 1'b0;
  assign ram_dout = mem[ram_addr];
  always @(posedge clk) begin
    if (fill_en) mem <= fill_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
  end

  // Reference model
  logic [3:0] ref_mem [16];
  int         ref_last;
  bit         exp_rv [2];
  logic [3:0] exp_rd [2];

`ifdef RAM_CLEAR_EN
  localparam bit CLEAR_BUILD = 1'b1;
`else
  localparam bit CLEAR_BUILD = 1'b0;
`endif

  task automatic model_reset();
    ref_last  = 1;
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    exp_rd[0] = 4'h0;
    exp_rd[1] = 4'h0;
  endtask

  task automatic drive_idle();
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 4'h0; req0_wdata = 4'h0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 4'h0; req1_wdata = 4'h0;
  endtask

  // Called at a negedge; checks the full clear sweep of 16 cycles
  task automatic sweep_check();
    for (int i = 0; i < 16; i++) begin
      req0_valid = 1'b1; req0_we = 1'b0;
      req1_valid = 1'b1; req1_we = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 4'(i) || ram_din !== 4'h0) begin
        errors++;
        $display("FAIL sweep[%0d]: busy=%b we=%b addr=%h din=%h, want busy=1 we=1 addr=%h din=0",
                 i, busy, ram_we, ram_addr, ram_din, 4'(i));
      end
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL sweep_ready[%0d]: ready0=%b ready1=%b, want 0 0", i, req0_ready, req1_ready);
      end
      @(negedge clk);
    end
    drive_idle();
    for (int i = 0; i < 16; i++) ref_mem[i] = 4'h0;
  endtask

  // Enter and leave reset, checking reset-time outputs; ends at a negedge in RUN
  task automatic do_reset(input bit do_fill);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || req0_rvalid !== 1'b0 || req1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: ready=%b%b rvalid=%b%b, want 00 00",
               req0_ready, req1_ready, req0_rvalid, req1_rvalid);
    end
    checks++;
    if (req0_rdata !== 4'h0 || req1_rdata !== 4'h0) begin
      errors++;
      $display("FAIL reset_rdata: rdata0=%h rdata1=%h, want 0 0", req0_rdata, req1_rdata);
    end
    checks++;
    if (ram_addr !== 4'h0 || ram_din !== 4'h0 || ram_we !== CLEAR_BUILD || busy !== CLEAR_BUILD) begin
      errors++;
      $display("FAIL reset_ram: addr=%h din=%h we=%b busy=%b, want 0 0 %b %b",
               ram_addr, ram_din, ram_we, busy, CLEAR_BUILD, CLEAR_BUILD);
    end
    fill_en = do_fill;
    @(negedge clk);
    fill_en = 1'b0;
    @(negedge clk);
    model_reset();
    if (do_fill) for (int i = 0; i < 16; i++) ref_mem[i] = fill_data[i];
    rst_n = 1'b1;
`ifdef RAM_CLEAR_EN
    sweep_check();
`endif
  endtask

  // One clock cycle in RUN: check previous-edge read results, present requests,
  // check grant and RAM drive, then update the model at the edge
  task automatic step(input bit v0, input bit w0, input logic [3:0] a0, input logic [3:0] d0,
                      input bit v1, input bit w1, input logic [3:0] a1, input logic [3:0] d1,
                      output bit g0, output bit g1);
    bit         eg0, eg1, ewe;
    logic [3:0] ea, ed;
    checks++;
    if (req0_rvalid !== exp_rv[0] || req0_rdata !== exp_rd[0]) begin
      errors++;
      $display("FAIL rd0: rvalid=%b rdata=%h, want rvalid=%b rdata=%h at %0t",
               req0_rvalid, req0_rdata, exp_rv[0], exp_rd[0], $time);
    end
    checks++;
    if (req1_rvalid !== exp_rv[1] || req1_rdata !== exp_rd[1]) begin
      errors++;
      $display("FAIL rd1: rvalid=%b rdata=%h, want rvalid=%b rdata=%h at %0t",
               req1_rvalid, req1_rdata, exp_rv[1], exp_rd[1], $time);
    end

    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    #1;

    if (v0 && v1) begin
      eg0 = (ref_last == 1);
      eg1 = !eg0;
    end else begin
      eg0 = v0;
      eg1 = v1;
    end
    ewe = 1'b0; ea = 4'h0; ed = 4'h0;
    if (eg0) begin ewe = w0; ea = a0; ed = d0; end
    else if (eg1) begin ewe = w1; ea = a1; ed = d1; end

    g0 = req0_ready;
    g1 = req1_ready;
    checks++;
    if (req0_ready !== eg0 || req1_ready !== eg1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL grant: ready0=%b ready1=%b busy=%b, want %b %b 0 at %0t",
               req0_ready, req1_ready, busy, eg0, eg1, $time);
    end
    checks++;
    if (ram_we !== ewe || ram_addr !== ea || ram_din !== ed) begin
      errors++;
      $display("FAIL ram_drive: we=%b addr=%h din=%h, want %b %h %h at %0t",
               ram_we, ram_addr, ram_din, ewe, ea, ed, $time);
    end

    @(posedge clk);
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    if (eg0) begin
      ref_last = 0;
      if (w0) ref_mem[a0] = d0;
      else begin exp_rv[0] = 1'b1; exp_rd[0] = ref_mem[a0]; end
    end else if (eg1) begin
      ref_last = 1;
      if (w1) ref_mem[a1] = d1;
      else begin exp_rv[1] = 1'b1; exp_rd[1] = ref_mem[a1]; end
    end
    @(negedge clk);
  endtask

  task automatic step_idle();
    bit g0, g1;
    step(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, g0, g1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) fill_data[i] = 4'($urandom_range(0, 15));
    do_reset(1'b1);
    step_idle();
  endtask

`ifdef RAM_CLEAR_EN
  task automatic test_clear_sweep();
    bit g0, g1;
    for (int i = 0; i < 16; i++) fill_data[i] = 4'hF;
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 4'(i), 4'h0, 0, 0, 4'h0, 4'h0, g0, g1);
    end
    step_idle();
  endtask

  task automatic test_reset_mid_sweep();
    drive_idle();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    #1;
    checks++;
    if (ram_addr !== 4'h7 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_sweep_pos: addr=%h busy=%b, want 7 1", ram_addr, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ram_addr !== 4'h0 || ram_we !== 1'b1 || busy !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_sweep_reset: addr=%h we=%b busy=%b ready0=%b, want 0 1 1 0",
               ram_addr, ram_we, busy, req0_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sweep_check();
    step_idle();
  endtask
`else
  task automatic test_no_clear();
    bit g0, g1;
    do_reset(1'b0);
    step(1, 0, 4'h9, 4'h0, 0, 0, 4'h0, 4'h0, g0, g1);
    checks++;
    if (g0 !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: ready0=%b, want 1", g0);
    end
    step_idle();
  endtask
`endif

  task automatic test_write_read();
    bit g0, g1;
    do_reset(1'b0);
    step(1, 1, 4'h3, 4'hA, 0, 0, 4'h0, 4'h0, g0, g1);
    step(1, 0, 4'h3, 4'h0, 0, 0, 4'h0, 4'h0, g0, g1);
    step_idle();
    checks++;
    if (req0_rdata !== 4'hA) begin
      errors++;
      $display("FAIL write_read_hold: rdata0=%h, want a", req0_rdata);
    end
  endtask

  task automatic test_contention();
    bit g0, g1;
    bit want0;
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 4'h1, 4'h0, 1, 0, 4'h2, 4'h0, g0, g1);
      want0 = (i % 2 == 0);
      checks++;
      if (g0 !== want0 || g1 !== !want0) begin
        errors++;
        $display("FAIL contention[%0d]: ready0=%b ready1=%b, want %b %b", i, g0, g1, want0, !want0);
      end
    end
    step_idle();
  endtask

  task automatic test_port1_then_both();
    bit g0, g1;
    do_reset(1'b0);
    repeat (3) step(0, 0, 4'h0, 4'h0, 1, 0, 4'h4, 4'h0, g0, g1);
    step(1, 0, 4'h5, 4'h0, 1, 0, 4'h4, 4'h0, g0, g1);
    checks++;
    if (g0 !== 1'b1 || g1 !== 1'b0) begin
      errors++;
      $display("FAIL tie_after_p1: ready0=%b ready1=%b, want 1 0", g0, g1);
    end
    step_idle();
  endtask

  task automatic test_mid_txn_reset();
    bit g0, g1;
    do_reset(1'b0);
    step(1, 0, 4'h5, 4'h0, 0, 0, 4'h0, 4'h0, g0, g1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (req0_rvalid !== 1'b0 || req0_rdata !== 4'h0 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_txn_reset: rvalid0=%b rdata0=%h ready0=%b, want 0 0 0",
               req0_rvalid, req0_rdata, req0_ready);
    end
    drive_idle();
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
`ifdef RAM_CLEAR_EN
    sweep_check();
`endif
    step_idle();
  endtask

  task automatic test_random();
    bit         pv [2];
    bit         pw [2];
    logic [3:0] pa [2];
    logic [3:0] pd [2];
    bit         g0, g1;
    do_reset(1'b0);
    for (int p = 0; p < 2; p++) begin pv[p] = 0; pw[p] = 0; pa[p] = 0; pd[p] = 0; end
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p]) begin
          if ($urandom_range(0, 2) != 0) begin
            pv[p] = 1'b1;
            pw[p] = 1'($urandom_range(0, 1));
            pa[p] = 4'($urandom_range(0, 15));
            pd[p] = 4'($urandom_range(0, 15));
          end
        end else if ($urandom_range(0, 7) == 0) begin
          pv[p] = 1'b0;
        end
      end
      step(pv[0], pw[0], pa[0], pd[0], pv[1], pw[1], pa[1], pd[1], g0, g1);
      if (g0) pv[0] = 1'b0;
      if (g1) pv[1] = 1'b0;
    end
    step_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    test_reset();
`ifdef RAM_CLEAR_EN
    test_clear_sweep();
    test_reset_mid_sweep();
`else
    test_no_clear();
`endif
    test_write_read();
    test_contention();
    test_port1_then_both();
    test_mid_txn_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
